// File: rtl/vga_sync_rx.sv
// vga_sync_rx - receive side of the 1024x768@60 VGA timing link.
//
// Samples HS/VS on every pixel strobe, regenerates the pixel coordinates
// with free-running counters that are re-aligned on each sync edge, checks
// line/frame timing against the nominal geometry and reports lock.
//
// Ports
//   CLK           in   system clock
//   RST_BTN       in   asynchronous active-low reset
//   pix_stb       in   pixel enable, one CLK cycle per pixel
//   hs_in, vs_in  in   horizontal / vertical sync (CLK domain)
//   o_x, o_y      out  coordinates of the pixel sampled at the last strobe
//   o_active      out  locked and inside the visible area
//   o_locked      out  timing lock
//   o_frame_start out  1-CLK pulse when coordinates become (0,0) while locked
//   o_err_cnt     out  saturating count of timing errors seen while locked
module vga_sync_rx #(
    parameter int H_ACTIVE    = 1024,
    parameter int H_FP        = 24,
    parameter int H_SYNC      = 136,
    parameter int H_TOTAL     = 1344,
    parameter int V_ACTIVE    = 768,
    parameter int V_FP        = 3,
    parameter int V_SYNC      = 6,
    parameter int V_TOTAL     = 806,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        CLK,
    input  logic        RST_BTN,
    input  logic        pix_stb,
    input  logic        hs_in,
    input  logic        vs_in,
    output logic [10:0] o_x,
    output logic [10:0] o_y,
    output logic        o_active,
    output logic        o_locked,
    output logic        o_frame_start,
    output logic [7:0]  o_err_cnt
);

    localparam int HS_STA = H_ACTIVE + H_FP;
    localparam int VS_STA = V_ACTIVE + V_FP;
    localparam int TMO    = 2 * H_TOTAL;
    localparam int TMO_W  = $clog2(TMO + 1);
    localparam int FR_W   = $clog2(LOCK_FRAMES + 1);

    localparam logic [10:0]      C_HS_STA   = 11'(HS_STA);
    localparam logic [10:0]      C_VS_STA   = 11'(VS_STA);
    localparam logic [10:0]      C_H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0]      C_V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0]      C_H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0]      C_V_ACT    = 11'(V_ACTIVE);
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TMO - 1);
    localparam logic [FR_W-1:0]  C_LOCK     = FR_W'(LOCK_FRAMES);

    // The sync pulse must fit between its start and the end of the line/frame.
    if ((HS_STA + H_SYNC > H_TOTAL) || (VS_STA + V_SYNC > V_TOTAL) ||
        (H_TOTAL > 2048) || (V_TOTAL > 2048)) begin : g_bad_timing
        $error("vga_sync_rx: inconsistent timing parameters");
    end

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [FR_W-1:0]   r_frames, w_frames_nxt;
    logic [10:0]       r_h_cnt, r_v_cnt;
    logic [10:0]       w_nxt_h, w_nxt_v, w_h_new, w_v_new;
    logic              r_hs_q, r_vs_q;
    logic              w_hs_edge, w_vs_edge;
    logic              w_h_err, w_v_err, w_t_err, w_err, w_err_inc;
    logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;

    // Counters, sync edge alignment and timing checks
    always_comb begin
        w_nxt_h = (r_h_cnt == C_H_LAST) ? 11'd0 : r_h_cnt + 11'd1;
        w_nxt_v = r_v_cnt;
        if (w_nxt_h == 11'd0)
            w_nxt_v = (r_v_cnt == C_V_LAST) ? 11'd0 : r_v_cnt + 11'd1;

        w_hs_edge = (hs_in == HS_POL) && (r_hs_q != HS_POL);
        w_vs_edge = (vs_in == VS_POL) && (r_vs_q != VS_POL);

        // A sync edge forces the counter to the sync start; the free-running
        // value tells whether the previous line/frame had nominal length.
        w_h_new = w_hs_edge ? C_HS_STA : w_nxt_h;
        w_v_new = w_vs_edge ? C_VS_STA : w_nxt_v;
        w_h_err = w_hs_edge && (w_nxt_h != C_HS_STA);
        w_v_err = w_vs_edge && (w_nxt_v != C_VS_STA);

        // Missing HS: one error every TMO strobes, counter restarts each time.
        w_t_err   = 1'b0;
        w_tmo_nxt = r_tmo + TMO_W'(1);
        if (w_hs_edge) begin
            w_tmo_nxt = '0;
        end else if (r_tmo == C_TMO_LAST) begin
            w_t_err   = 1'b1;
            w_tmo_nxt = '0;
        end

        w_err = w_h_err | w_v_err | w_t_err;
    end

    // Lock FSM: next state
    always_comb begin
        w_state_nxt  = r_state;
        w_frames_nxt = r_frames;
        w_err_inc    = 1'b0;
        case (r_state)
            S_SEARCH: begin
                if (w_vs_edge) begin
                    w_state_nxt  = S_VERIFY;
                    w_frames_nxt = '0;
                end
            end
            S_VERIFY: begin
                if (w_err) begin
                    w_state_nxt = S_SEARCH;
                end else if (w_vs_edge) begin
                    w_frames_nxt = r_frames + FR_W'(1);
                    if (w_frames_nxt == C_LOCK)
                        w_state_nxt = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (w_err) begin
                    w_state_nxt = S_SEARCH;
                    w_err_inc   = 1'b1;
                end
            end
            default: w_state_nxt = S_SEARCH;
        endcase
    end

    // Lock FSM: state register
    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            r_state  <= S_SEARCH;
            r_frames <= '0;
        end else if (pix_stb) begin
            r_state  <= w_state_nxt;
            r_frames <= w_frames_nxt;
        end
    end

    // Datapath registers and outputs
    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_hs_q        <= ~HS_POL;
            r_vs_q        <= ~VS_POL;
            r_tmo         <= '0;
            o_locked      <= 1'b0;
            o_frame_start <= 1'b0;
            o_err_cnt     <= '0;
        end else begin
            o_frame_start <= 1'b0;
            if (pix_stb) begin
                r_h_cnt       <= w_h_new;
                r_v_cnt       <= w_v_new;
                r_hs_q        <= hs_in;
                r_vs_q        <= vs_in;
                r_tmo         <= w_tmo_nxt;
                o_locked      <= (w_state_nxt == S_LOCKED);
                o_frame_start <= (w_state_nxt == S_LOCKED) &&
                                 (w_h_new == 11'd0) && (w_v_new == 11'd0);
                if (w_err_inc && (o_err_cnt != 8'hFF))
                    o_err_cnt <= o_err_cnt + 8'd1;
            end
        end
    end

    // The counters already hold the coordinates of the last sampled pixel.
    assign o_x      = r_h_cnt;
    assign o_y      = r_v_cnt;
    assign o_active = o_locked && (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT);

endmodule
